seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the BCD/hex-to-7-segment encoder: samples a multiplexed (scanned) 7-segment bus, decodes each digit's segment pattern back to a 4-bit hex value, and filters glitches with a per-digit stability counter. Once every digit has a stable pattern, it assembles a full frame and presents it through a valid/ready handshake. It sits between the display-drive path and self-check or readback logic that needs the digits as numbers.

## Interface
Parameters:
- DIGITS, 4, number of scanned digit positions (1-8).
- STABLE_CNT, 3, consecutive identical samples needed to commit a digit (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- sample_en  input  1  sample strobe; seg_in/an_in are valid only when high.
- an_in  input  DIGITS  one-hot digit select, active high; bit i = digit i.
- seg_in  input  8  segments, active high: [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp.
- digits  output  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- dp_out  output  DIGITS  captured decimal points.
- err  output  DIGITS  digit i's committed pattern matched no hex glyph.
- frame_valid  output  1  frame on digits/dp_out/err is valid.
- frame_ready  input  1  consumer accepts frame.
- overrun  output  1  sticky: a completed frame was dropped.

## Operation
- Glyph table, seg_in[7:1] with dp masked: 0=0xFC, 1=0x60, 2=0xDA, 3=0xF2, 4=0x66, 5=0xB6, 6=0xBE, 7=0xE0, 8=0xFE, 9=0xF6, A=0xEE, b=0x3E, C=0x9C, d=0x7A, E=0x9E, F=0x8E.
- Any other pattern decodes to nibble 0 and sets err for that digit. Blank (0x00) is also an error.
- A sample is accepted when sample_en=1 and an_in is exactly one-hot. A zero or multi-hot an_in is ignored and changes no state.
- Per-digit state:
  - last pattern (8 bits) and stability counter, width $clog2(STABLE_CNT+1).
  - On an accepted sample for digit i:
    - Pattern equals last and digit is not committed: counter increments, saturating at STABLE_CNT.
    - Pattern differs: last is updated and counter is set to 1.
  - When the counter reaches STABLE_CNT, the digit commits: nibble, dp and err go to staging, and the committed bit is set.
  - Later samples of a committed digit are ignored until the frame is emitted.
- Frame state machine:
  - COLLECT: waits until all committed bits are set.
  - Frame complete and output free (frame_valid=0, or frame_valid=1 and frame_ready=1 in the same cycle):
    - staging loads into the outputs and frame_valid is set;
    - committed bits and counters clear and the machine stays in COLLECT.
  - Frame complete but output held (frame_valid=1, frame_ready=0):
    - the frame is dropped and overrun is set;
    - committed bits and counters clear and collection restarts.
- Handshake:
  - frame_valid stays high with stable outputs until a cycle with frame_ready=1.
  - frame_valid drops the cycle after that transfer, unless a new frame loads in the same cycle.
- overrun clears only on reset.

## Timing
- Reset (rst_n=0 at a clk edge): digits=0, dp_out=0, err=0, frame_valid=0, overrun=0. All counters, last patterns, staging and committed bits clear.
- Reset mid-collection or mid-handshake discards everything; there is no partial frame afterwards.
- Commit latency: digit i commits on the clk edge of its STABLE_CNT-th consecutive identical accepted sample.
- Frame latency: frame_valid rises on the same edge the last digit commits. Outputs are registered.
- With STABLE_CNT=1, every first sample commits.
- A sample accepted in the same cycle a frame emits counts toward the next frame.
- Minimum frame spacing: DIGITS×STABLE_CNT accepted samples.

## Configuration
- SEG7_DP_CAPTURE_EN defined:
  - seg_in[0] is part of the stability comparison;
  - dp_out reports the committed dp per digit.
- Undefined:
  - seg_in[0] is ignored in both comparison and decode;
  - dp_out is tied to 0.
- Glyph matching always masks dp in both builds.

## Test plan
- Reset: hold rst_n=0 two cycles with random inputs -> all outputs 0, frame_valid=0.
- Clean frame: DIGITS=4, STABLE_CNT=3; scan digits 0..3 with 0xF2, 0x66, 0xB6, 0xFE, three samples each -> frame_valid=1, digits=16'h8543, err=0.
- Glitch filter: digit 0 samples 0x60, 0x60, 0xDA, 0xDA, 0xDA -> digit 0 commits 2, not 1.
- Invalid pattern plus illegal select: digit 2 sampled with 0x02 three times; an_in=4'b0110 interleaved -> err[2]=1, digits[11:8]=0, and the 4'b0110 samples have no effect.
- Backpressure: frame_ready=0 while two full frames complete -> first frame held unchanged, overrun=1, second frame dropped. Then frame_ready=1 for one cycle -> frame_valid=0 next cycle.
- Decimal point: digit 1 with 0xFD, once with SEG7_DP_CAPTURE_EN defined and once without -> dp_out[1]=1 and 0 respectively; digits[7:4]=0 in both.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//
// Receive-side decoder for a scanned 7-segment bus. Each accepted sample
// (sample_en high, an_in exactly one-hot) feeds one digit's stability filter.
// A digit commits once it has seen STABLE_CNT consecutive identical patterns.
// Its decoded nibble, dp and glyph error then go to staging. When every digit
// has committed, the staged frame is presented on a valid/ready output.
//
// Optional feature macro: SEG7_DP_CAPTURE_EN
//   defined   - seg_in[0] (dp) takes part in the stability compare and is
//               reported per digit on dp_out
//   undefined - seg_in[0] is ignored and dp_out is tied low
//
// Parameters:
//   DIGITS      number of scanned digit positions (1-8)
//   STABLE_CNT  consecutive identical samples needed to commit a digit (>=1)
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sample_en    sample strobe, qualifies an_in/seg_in
//   an_in        one-hot digit select, bit i = digit i
//   seg_in       segments a..g on [7:1], dp on [0], active high
//   digits       decoded nibbles, digit i at [4i+3:4i]
//   dp_out       captured decimal points
//   err          digit pattern matched no hex glyph
//   frame_valid  output frame valid
//   frame_ready  consumer accepts frame
//   overrun      sticky, a completed frame was dropped under backpressure

module seg7_scan_decoder #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [DIGITS-1:0]     an_in,
  input  logic [7:0]            seg_in,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(STABLE_CNT);
  localparam cnt_t CntOne = cnt_t'(1);

  // Returns {err, nibble}; dp is always masked out of glyph matching.
  function automatic logic [4:0] decode_glyph(input logic [7:0] seg);
    logic [4:0] res;
    case ({seg[7:1], 1'b0})
      8'hFC:   res = 5'h00;
      8'h60:   res = 5'h01;
      8'hDA:   res = 5'h02;
      8'hF2:   res = 5'h03;
      8'h66:   res = 5'h04;
      8'hB6:   res = 5'h05;
      8'hBE:   res = 5'h06;
      8'hE0:   res = 5'h07;
      8'hFE:   res = 5'h08;
      8'hF6:   res = 5'h09;
      8'hEE:   res = 5'h0A;
      8'h3E:   res = 5'h0B;
      8'h9C:   res = 5'h0C;
      8'h7A:   res = 5'h0D;
      8'h9E:   res = 5'h0E;
      8'h8E:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  // Per-digit filter state
  logic [DIGITS-1:0][7:0] last_q, last_d;
  logic [DIGITS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0]       com_q, com_d;

  // Staging for the frame under collection
  logic [DIGITS-1:0][3:0]  stg_nib_q, stg_nib_d;
  logic [DIGITS-1:0]       stg_err_q, stg_err_d;

  // Registered outputs
  logic [DIGITS-1:0][3:0]  dig_q;
  logic [DIGITS-1:0]       err_q;
  logic                    valid_q;
  logic                    overrun_q;

  logic       accept;
  logic [7:0] pat;
  logic [4:0] glyph;
  logic       frame_done;
  logic       out_free;

`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0] dp_q;
  assign pat    = seg_in;
  assign dp_out = dp_q;
`else
  logic unused_dp;
  assign unused_dp = seg_in[0];
  assign pat       = {seg_in[7:1], 1'b0};
  assign dp_out    = '0;
`endif

  // A zero or multi-hot select is not a sample at all.
  assign accept = sample_en && (an_in != '0) && ((an_in & (an_in - DIGITS'(1))) == '0);
  assign glyph  = decode_glyph(pat);

  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    com_d     = com_q;
    stg_nib_d = stg_nib_q;
    stg_err_d = stg_err_q;
`ifdef SEG7_DP_CAPTURE_EN
    stg_dp_d  = stg_dp_q;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (accept && an_in[i] && !com_q[i]) begin
        if (pat == last_q[i]) begin
          if (cnt_q[i] != CntMax) begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end else begin
          last_d[i] = pat;
          cnt_d[i]  = CntOne;
        end
        if (cnt_d[i] == CntMax) begin
          com_d[i]     = 1'b1;
          stg_nib_d[i] = glyph[3:0];
          stg_err_d[i] = glyph[4];
`ifdef SEG7_DP_CAPTURE_EN
          stg_dp_d[i]  = seg_in[0];
`endif
        end
      end
    end

    // Completion uses next-state commits so the frame emits on the same edge
    // as the last digit commits.
    frame_done = &com_d;
    out_free   = !valid_q || frame_ready;

    // Whether loaded or dropped, a completed frame restarts collection.
    if (frame_done) begin
      com_d = '0;
      cnt_d = '0;
    end
  end

  // The frame machine has a single collecting state, so its behaviour is
  // captured entirely by valid_q and overrun_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= '0;
      cnt_q     <= '0;
      com_q     <= '0;
      stg_nib_q <= '0;
      stg_err_q <= '0;
      dig_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      stg_dp_q  <= '0;
      dp_q      <= '0;
`endif
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      com_q     <= com_d;
      stg_nib_q <= stg_nib_d;
      stg_err_q <= stg_err_d;
`ifdef SEG7_DP_CAPTURE_EN
      stg_dp_q  <= stg_dp_d;
`endif
      if (frame_done && out_free) begin
        dig_q   <= stg_nib_d;
        err_q   <= stg_err_d;
        valid_q <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
        dp_q    <= stg_dp_d;
`endif
      end else begin
        if (frame_done) begin
          overrun_q <= 1'b1;
        end
        if (valid_q && frame_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign digits      = dig_q;
  assign err         = err_q;
  assign frame_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (DIGITS=4, STABLE_CNT=3).
// Expected frames are queued when their stimulus is driven; a monitor pops
// and compares them whenever the DUT loads a new frame onto its outputs.

module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  dp_out;
  logic [3:0]  err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  seg7_scan_decoder #(
    .DIGITS     (4),
    .STABLE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digits      (digits),
    .dp_out      (dp_out),
    .err         (err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  e;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

`ifdef SEG7_DP_CAPTURE_EN
  localparam logic [3:0] DpExp = 4'b0010;
`else
  localparam logic [3:0] DpExp = 4'b0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample at a negedge; returns at the next negedge.
  task automatic do_sample(input logic [3:0] an, input logic [7:0] seg, input logic en = 1'b1);
    sample_en = en;
    an_in     = an;
    seg_in    = seg;
    @(negedge clk);
    sample_en = 1'b0;
    an_in     = '0;
    seg_in    = '0;
  endtask

  // Round-robin scan of all four digits, three passes.
  task automatic scan3(input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3);
    for (int k = 0; k < 3; k++) begin
      do_sample(4'b0001, p0);
      do_sample(4'b0010, p1);
      do_sample(4'b0100, p2);
      do_sample(4'b1000, p3);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] e);
    frame_t f;
    f.d  = d;
    f.dp = dp;
    f.e  = e;
    exp_q.push_back(f);
  endtask

  task automatic idle_and_drain(input string tag);
    repeat (3) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // Monitor: a new frame is loaded when valid rises, or stays high right
  // after a transfer.
  always @(posedge clk) begin
    logic fv_old, rdy_old, rst_old;
    frame_t f;
    fv_old  = frame_valid;
    rdy_old = frame_ready;
    rst_old = rst_n;
    #1;
    if (rst_old && frame_valid && (!fv_old || rdy_old)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 0, 1);
      end else begin
        f = exp_q.pop_front();
        check("frame_digits", digits, f.d);
        check("frame_dp", dp_out, f.dp);
        check("frame_err", err, f.e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    sample_en   = 1'b0;
    an_in       = '0;
    seg_in      = '0;
    frame_ready = 1'b0;

    // Reset with random inputs
    repeat (2) begin
      @(negedge clk);
      sample_en   = 1'($urandom);
      an_in       = 4'($urandom);
      seg_in      = 8'($urandom);
      frame_ready = 1'($urandom);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    sample_en   = 1'b0;
    an_in       = '0;
    seg_in      = '0;
    frame_ready = 1'b1;
    check("rst_digits", digits, 0);
    check("rst_dp", dp_out, 0);
    check("rst_err", err, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_overrun", overrun, 0);

    // Clean frame
    push(16'h8543, 4'b0000, 4'b0000);
    scan3(8'hF2, 8'h66, 8'hB6, 8'hFE);
    check("clean_valid", frame_valid, 1);
    check("clean_digits", digits, 16'h8543);
    check("clean_err", err, 0);
    @(negedge clk);
    check("clean_valid_drop", frame_valid, 0);
    idle_and_drain("clean_pending");

    // Glitch filter, then samples of a committed digit are ignored
    push(16'hBA02, 4'b0000, 4'b0000);
    do_sample(4'b0001, 8'h60);
    do_sample(4'b0001, 8'h60);
    repeat (3) do_sample(4'b0001, 8'hDA);
    repeat (3) do_sample(4'b0001, 8'h60);
    repeat (3) do_sample(4'b0010, 8'hFC);
    repeat (3) do_sample(4'b0100, 8'hEE);
    repeat (3) do_sample(4'b1000, 8'h3E);
    check("glitch_digit0", digits[3:0], 4'h2);
    idle_and_drain("glitch_pending");

    // Invalid pattern on digit 2, interleaved with non-accepted samples
    push(16'hE0DC, 4'b0000, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      do_sample(4'b0100, 8'h02);
      do_sample(4'b0110, 8'hFC);
      do_sample(4'b0100, 8'h60, 1'b0);
      do_sample(4'b0000, 8'hFC);
    end
    repeat (3) do_sample(4'b0001, 8'h9C);
    repeat (3) do_sample(4'b0010, 8'h7A);
    repeat (3) do_sample(4'b1000, 8'h9E);
    check("inval_err", err, 4'b0100);
    check("inval_nib2", digits[11:8], 4'h0);
    idle_and_drain("inval_pending");

    // New frame completes in the same cycle the held frame is accepted
    frame_ready = 1'b0;
    push(16'h9999, 4'b0000, 4'b0000);
    scan3(8'hF6, 8'hF6, 8'hF6, 8'hF6);
    push(16'h8765, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      do_sample(4'b0001, 8'hB6);
      do_sample(4'b0010, 8'hBE);
      do_sample(4'b0100, 8'hE0);
      if (k == 2) frame_ready = 1'b1;
      do_sample(4'b1000, 8'hFE);
    end
    check("coinc_valid", frame_valid, 1);
    check("coinc_digits", digits, 16'h8765);
    check("coinc_overrun", overrun, 0);
    idle_and_drain("coinc_pending");

    // Backpressure: second frame dropped, first held
    frame_ready = 1'b0;
    push(16'h697F, 4'b0000, 4'b0000);
    scan3(8'h8E, 8'hE0, 8'hF6, 8'hBE);
    check("bp_overrun_a", overrun, 0);
    scan3(8'h60, 8'h60, 8'h60, 8'h60);
    check("bp_held_valid", frame_valid, 1);
    check("bp_held_digits", digits, 16'h697F);
    check("bp_overrun_b", overrun, 1);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("bp_valid_drop", frame_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    check("bp_pending", exp_q.size(), 0);
    frame_ready = 1'b1;

    // Decimal point on digit 1
    push(16'h0000, DpExp, 4'b0000);
    scan3(8'hFC, 8'hFD, 8'hFC, 8'hFC);
    check("dp_bit1", dp_out[1], DpExp[1]);
    check("dp_nib1", digits[7:4], 4'h0);
    idle_and_drain("dp_pending");

    // Reset mid-collection discards partial commits
    repeat (3) do_sample(4'b0001, 8'h60);
    repeat (2) do_sample(4'b0010, 8'h66);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_digits", digits, 0);
    check("mrst_valid", frame_valid, 0);
    check("mrst_overrun", overrun, 0);
    push(16'h8543, 4'b0000, 4'b0000);
    scan3(8'hF2, 8'h66, 8'hB6, 8'hFE);
    check("mrst_frame_digits", digits, 16'h8543);
    idle_and_drain("mrst_pending");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
